// File: rtl/multicycle_execute_unit.sv
// Multicycle MIPS-subset execute unit: each accepted instruction walks IDLE->DECODE->EXECUTE->WRITEBACK
// against an internal register file that resets to R[i]=i, exposing registered operand/result buses.
module multicycle_execute_unit #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] busW,
    output logic              done,
    output logic              ovf,
    output logic              illegal
);
    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ILL} op_t;

    state_t            r_state;
    op_t               r_op;
    logic [31:0]       r_instr;
    logic [4:0]        r_dest;
    logic              r_ready;
    logic              r_done;
    logic              r_ovf;
    logic              r_illegal;
    logic [DATA_W-1:0] r_busA;
    logic [DATA_W-1:0] r_busB;
    logic [DATA_W-1:0] r_busW;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_imm_sx;
    logic [DATA_W-1:0] w_imm_zx;
    logic              w_rs_ok;
    logic              w_rt_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    op_t               w_op;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_opb;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_ovf;
    logic              w_unused;

    assign w_opcode = r_instr[31:26];
    assign w_rs     = r_instr[25:21];
    assign w_rt     = r_instr[20:16];
    assign w_rd     = r_instr[15:11];
    assign w_funct  = r_instr[5:0];
    assign w_imm    = r_instr[15:0];
    assign w_unused = ^r_instr[10:6];

    // Extend to 64 bits first, then truncate, so narrow datapaths keep the low bits of the extended value.
    assign w_imm_sx = DATA_W'({{48{w_imm[15]}}, w_imm});
    assign w_imm_zx = DATA_W'({48'd0, w_imm});

    assign w_rs_ok  = int'({27'd0, w_rs}) < NREGS;
    assign w_rt_ok  = int'({27'd0, w_rt}) < NREGS;
    assign w_rd_ok  = int'({27'd0, w_rd}) < NREGS;
    assign w_rs_val = (w_rs != 5'd0 && w_rs_ok) ? r_regs[w_rs[IDXW-1:0]] : '0;
    assign w_rt_val = (w_rt != 5'd0 && w_rt_ok) ? r_regs[w_rt[IDXW-1:0]] : '0;

    always_comb begin
        w_op   = OP_ILL;
        w_dest = w_rt;
        w_opb  = w_imm_zx;
        if (w_opcode == 6'h00) begin
            w_dest = w_rd;
            w_opb  = w_rt_val;
            case (w_funct)
                6'h20:   w_op = OP_ADD;
                6'h22:   w_op = OP_SUB;
                6'h24:   w_op = OP_AND;
                6'h25:   w_op = OP_OR;
                6'h2A:   w_op = OP_SLT;
                default: w_op = OP_ILL;
            endcase
            if (!(w_rs_ok && w_rt_ok && w_rd_ok)) w_op = OP_ILL;
        end else begin
            case (w_opcode)
                6'h08:   begin w_op = OP_ADD; w_opb = w_imm_sx; end
                6'h0C:   w_op = OP_AND;
                6'h0D:   w_op = OP_OR;
                default: w_op = OP_ILL;
            endcase
            if (!(w_rs_ok && w_rt_ok)) w_op = OP_ILL;
        end
    end

    assign w_sum  = r_busA + r_busB;
    assign w_diff = r_busA - r_busB;

    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (r_busA[DATA_W-1] == r_busB[DATA_W-1]) && (w_sum[DATA_W-1] != r_busA[DATA_W-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (r_busA[DATA_W-1] != r_busB[DATA_W-1]) && (w_diff[DATA_W-1] != r_busA[DATA_W-1]);
            end
            OP_AND:  w_result = r_busA & r_busB;
            OP_OR:   w_result = r_busA | r_busB;
            OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(r_busA) < $signed(r_busB))};
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_op      <= OP_ILL;
            r_instr   <= '0;
            r_dest    <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
            r_busA    <= '0;
            r_busB    <= '0;
            r_busW    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr <= instr;
                        r_ready <= 1'b0;
                        r_state <= DECODE;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                DECODE: begin
                    r_busA  <= w_rs_val;
                    r_busB  <= w_opb;
                    r_op    <= w_op;
                    r_dest  <= w_dest;
                    r_state <= EXECUTE;
                end
                EXECUTE: begin
                    r_busW    <= w_result;
                    r_ovf     <= w_ovf;
                    r_illegal <= (r_op == OP_ILL);
                    r_state   <= WRITEBACK;
                end
                WRITEBACK: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < unsigned'(NREGS); i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else if (r_state == WRITEBACK && r_op != OP_ILL && r_dest != 5'd0) begin
            r_regs[r_dest[IDXW-1:0]] <= r_busW;
        end
    end

    assign instr_ready = r_ready;
    assign busA        = r_busA;
    assign busB        = r_busB;
    assign busW        = r_busW;
    assign done        = r_done;
    assign ovf         = r_ovf;
    assign illegal     = r_illegal;
endmodule

// File: tb/tb_multicycle_execute_unit.sv
// Scoreboard bench for multicycle_execute_unit: a 32-bit/32-reg and an 8-bit/8-reg instance,
// with expected results predicted at issue time and compared when done pulses.
module tb_multicycle_execute_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32_n, rst8_n;
    logic [31:0] instr32, instr8;
    logic        valid32, valid8;
    logic        rdy32, rdy8, done32, done8, ovf32, ovf8, ill32, ill8;
    logic [31:0] a32, b32, w32;
    logic [7:0]  a8, b8, w8;

    multicycle_execute_unit #(.DATA_W(32), .NREGS(32)) u_dut32 (
        .CLK(clk), .RST_N(rst32_n), .instr(instr32), .instr_valid(valid32), .instr_ready(rdy32),
        .busA(a32), .busB(b32), .busW(w32), .done(done32), .ovf(ovf32), .illegal(ill32)
    );

    multicycle_execute_unit #(.DATA_W(8), .NREGS(8)) u_dut8 (
        .CLK(clk), .RST_N(rst8_n), .instr(instr8), .instr_valid(valid8), .instr_ready(rdy8),
        .busA(a8), .busB(b8), .busW(w8), .done(done8), .ovf(ovf8), .illegal(ill8)
    );

    typedef struct {
        logic [63:0] a, b, w;
        logic        ovf, ill;
        int unsigned acc;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        e32, e8;
    logic [63:0] m_rf [2][32];
    int unsigned cyc = 0;
    int unsigned last_acc [2] = '{0, 0};
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [63:0] v, input int dw);
        logic [63:0] mask;
        mask = (64'd1 << dw) - 64'd1;
        return v[dw-1] ? (v | ~mask) : (v & mask);
    endfunction

    task automatic model_reset(input int s);
        for (int i = 0; i < 32; i++) m_rf[s][i] = (s == 1 && i >= 8) ? 64'd0 : 64'(i);
    endtask

    task automatic predict(input bit s, input logic [31:0] ins, output exp_t e);
        int          dw, nr;
        logic [63:0] mask, a, b, sa, sb, full, res;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dst;
        logic [15:0] imm;
        logic        legal, o;
        dw = s ? 8 : 32;
        nr = s ? 8 : 32;
        mask = (64'd1 << dw) - 64'd1;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0]; imm = ins[15:0];
        a = (int'(rs) < nr) ? m_rf[s][rs] : 64'd0;
        if (op == 6'h00) begin
            dst = rd;
            b = (int'(rt) < nr) ? m_rf[s][rt] : 64'd0;
            legal = (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) && int'(rs) < nr && int'(rt) < nr && int'(rd) < nr;
        end else begin
            dst = rt;
            b = (op == 6'h08) ? ({{48{imm[15]}}, imm} & mask) : {48'd0, imm};
            b = b & mask;
            legal = (op inside {6'h08, 6'h0C, 6'h0D}) && int'(rs) < nr && int'(rt) < nr;
        end
        sa = sx(a, dw);
        sb = sx(b, dw);
        full = 64'd0;
        o = 1'b0;
        if ((op == 6'h00 && fn == 6'h20) || op == 6'h08) begin
            full = sa + sb;
            o = sx(full & mask, dw) != full;
        end else if (op == 6'h00 && fn == 6'h22) begin
            full = sa - sb;
            o = sx(full & mask, dw) != full;
        end else if ((op == 6'h00 && fn == 6'h24) || op == 6'h0C) full = a & b;
        else if ((op == 6'h00 && fn == 6'h25) || op == 6'h0D) full = a | b;
        else if (op == 6'h00 && fn == 6'h2A) full = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
        res = full & mask;
        if (!legal) begin
            res = 64'd0;
            o = 1'b0;
        end
        e.a = a; e.b = b; e.w = res; e.ovf = o; e.ill = !legal; e.acc = 0;
        if (legal && dst != 5'd0) m_rf[s][dst] = res;
    endtask

    task automatic score(input string who, input exp_t e, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] w, input logic o, input logic il);
        check_eq({who, "_latency"}, 64'(cyc - e.acc), 64'd3);
        if (!e.ill) begin
            check_eq({who, "_busA"}, a, e.a);
            check_eq({who, "_busB"}, b, e.b);
        end
        check_eq({who, "_busW"}, w, e.w);
        check_eq({who, "_ovf"}, 64'(o), 64'(e.ovf));
        check_eq({who, "_illegal"}, 64'(il), 64'(e.ill));
    endtask

    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) check_eq("spurious_done32", 64'(done32), 64'd0);
            else begin
                e32 = q32.pop_front();
                score("dut32", e32, 64'(a32), 64'(b32), 64'(w32), ovf32, ill32);
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) check_eq("spurious_done8", 64'(done8), 64'd0);
            else begin
                e8 = q8.pop_front();
                score("dut8", e8, 64'(a8), 64'(b8), 64'(w8), ovf8, ill8);
            end
        end
    end

    task automatic issue(input bit s, input logic [31:0] ins, input bit push, input bit hold);
        exp_t        e;
        int unsigned n, acc;
        @(negedge clk);
        n = 0;
        while (!(s ? rdy8 : rdy32) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", 64'(s ? rdy8 : rdy32), 64'd1);
        if (s) begin instr8 = ins; valid8 = 1'b1; end
        else begin instr32 = ins; valid32 = 1'b1; end
        acc = cyc + 1;
        if (hold && last_acc[s] != 0) check_eq("b2b_spacing", 64'(acc - last_acc[s]), 64'd4);
        last_acc[s] = hold ? acc : 0;
        if (push) begin
            predict(s, ins, e);
            e.acc = acc;
            if (s) q8.push_back(e);
            else q32.push_back(e);
        end
        @(posedge clk);
        #1;
        if (s) begin instr8 = $urandom; valid8 = hold; end
        else begin instr32 = $urandom; valid32 = hold; end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 31));
        rt = 5'($urandom_range(0, 31));
        rd = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            5: return {6'h08, rs, rt, imm};
            6: return {6'h0C, rs, rt, imm};
            default: return {6'h0D, rs, rt, imm};
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int unsigned n;
        rst32_n = 1'b0; rst8_n = 1'b0;
        valid32 = 1'b0; valid8 = 1'b0;
        instr32 = '0; instr8 = '0;
        model_reset(0);
        model_reset(1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready32", 64'(rdy32), 64'd0);
        check_eq("rst_busA32", 64'(a32), 64'd0);
        check_eq("rst_busB32", 64'(b32), 64'd0);
        check_eq("rst_busW32", 64'(w32), 64'd0);
        check_eq("rst_flags32", {61'd0, done32, ovf32, ill32}, 64'd0);
        check_eq("rst_ready8", 64'(rdy8), 64'd0);
        @(negedge clk);
        rst32_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst32", 64'(rdy32), 64'd1);
        check_eq("ready_after_rst8", 64'(rdy8), 64'd1);

        issue(0, 32'h00221820, 1, 0);                   // add  $3,$1,$2
        issue(0, 32'h00602025, 1, 0);                   // or   $4,$3,$0
        issue(0, 32'h2005FFFF, 1, 0);                   // addi $5,$0,0xFFFF
        issue(0, 32'h00A1302A, 1, 0);                   // slt  $6,$5,$1
        issue(0, 32'h00223822, 1, 0);                   // sub  $7,$1,$2
        issue(0, 32'h20087FFF, 1, 0);                   // addi $8,$0,0x7FFF
        for (int k = 0; k < 17; k++) issue(0, 32'h01084020, 1, 0);  // add $8,$8,$8
        issue(0, 32'h30A900F0, 1, 0);                   // andi $9,$5,0x00F0
        issue(0, 32'h340A8001, 1, 0);                   // ori  $10,$0,0x8001
        issue(0, 32'hFC251234, 1, 0);                   // opcode 0x3F targeting rt=$5
        issue(0, 32'h00A05820, 1, 0);                   // add  $11,$5,$0 re-read
        issue(0, 32'h00223021, 1, 0);                   // funct 0x21 targeting rd=$6
        issue(0, 32'h00C06025, 1, 0);                   // or   $12,$6,$0 re-read
        issue(0, 32'h20200005, 1, 0);                   // addi $0,$1,5
        issue(0, 32'h00016820, 1, 0);                   // add  $13,$0,$1
        for (int k = 0; k < 8; k++) issue(0, rand_instr(), 1, 1);
        valid32 = 1'b0;
        last_acc[0] = 0;

        issue(1, 32'h20010080, 1, 0);                   // addi $1,$0,0x0080
        issue(1, 32'h00224820, 1, 0);                   // add  $9,$1,$2 (rd out of range)
        issue(1, 32'h01211820, 1, 0);                   // add  $3,$9,$1 (rs out of range)
        issue(1, 32'h00602025, 1, 0);                   // or   $4,$3,$0 re-read
        issue(1, 32'h00221820, 0, 0);                   // add  $3,$1,$2, aborted below
        @(posedge clk);
        #1;
        rst8_n = 1'b0;
        #1;
        check_eq("abort_ready8", 64'(rdy8), 64'd0);
        check_eq("abort_busW8", 64'(w8), 64'd0);
        check_eq("abort_busA8", 64'(a8), 64'd0);
        check_eq("abort_done8", 64'(done8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst8_n = 1'b1;
        model_reset(1);
        @(posedge clk);
        #1;
        check_eq("ready_after_abort8", 64'(rdy8), 64'd1);
        issue(1, 32'h00602025, 1, 0);                   // or   $4,$3,$0 re-read
        issue(1, 32'h2002007F, 1, 0);                   // addi $2,$0,0x7F
        issue(1, 32'h00421020, 1, 0);                   // add  $2,$2,$2 overflows
        issue(1, 32'h00221820, 1, 0);                   // add  $3,$1,$2

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain32", 64'(q32.size()), 64'd0);
        check_eq("drain8", 64'(q8.size()), 64'd0);
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
